subservient_sram_arbiter: RTL and testbench
===========================================

# subservient_sram_arbiter

Owns the single 8-bit SRAM port of the subservient SoC and shares it between the core's byte interface and the 32-bit Wishbone debug port. When debug mode is active, an FSM splits each 32-bit debug access into four sequential byte-lane SRAM accesses and returns a single-cycle ack. Otherwise, the core drives the SRAM. It sits between `subservient` core logic and the external SRAM pins, and replaces ad-hoc debug muxing.

## Interface
- `memsize`, 8192, SRAM size in bytes
- `aw`, `$clog2(memsize)`, SRAM byte address width
- `i_clk` in 1: sole clock, rising edge
- `i_rst` in 1: asynchronous, active-high reset
- `i_debug_mode` in 1: debug port requests SRAM ownership
- `i_core_waddr` in aw / `i_core_wdata` in 8 / `i_core_wen` in 1: core write request
- `i_core_raddr` in aw / `i_core_ren` in 1: core read request
- `o_core_rdata` out 8: read data, equal to `i_sram_rdata`
- `o_core_stall` out 1: core requests are being dropped because debug owns the SRAM
- `i_wb_dbg_adr` in 32 / `i_wb_dbg_dat` in 32 / `i_wb_dbg_sel` in 4 / `i_wb_dbg_we` in 1 / `i_wb_dbg_stb` in 1: debug request
- `o_wb_dbg_rdt` out 32 / `o_wb_dbg_ack` out 1: debug response
- `o_sram_waddr` out aw / `o_sram_wdata` out 8 / `o_sram_wen` out 1: SRAM write port
- `o_sram_raddr` out aw / `o_sram_ren` out 1 / `i_sram_rdata` in 8: SRAM read port, 1-cycle read latency

## Operation
- **FSM states:**
  - IDLE → LANE when `i_debug_mode & i_wb_dbg_stb` is high.
  - LANE counts a 2-bit lane counter from 0 to 3.
  - After lane 3: writes go to ACK; reads go to RWAIT.
  - RWAIT → ACK.
  - ACK → IDLE.
- **Debug ownership:** active when state ≠ IDLE, or when `i_debug_mode` is high. Otherwise, core signals pass combinationally to the SRAM ports.
- **Core requests while debug owns:**
  - Core requests are dropped: SRAM `wen`/`ren` from the core are forced to 0.
  - `o_core_stall` is 1 when (`i_core_wen | i_core_ren`) is high and debug owns.
- **Request latching:** `adr`, `dat`, `sel`, and `we` are latched on the IDLE→LANE edge. Bus changes during the transaction are ignored.
- **LANE k, write:**
  - `o_sram_waddr` = {`adr[aw-1:2]`, k}
  - `o_sram_wdata` = `dat[8k+:8]`
  - `o_sram_wen` = `sel[k]`
  - Each lane takes one cycle, even when its `sel` bit is 0.
- **LANE k, read:**
  - `o_sram_raddr` = {`adr[aw-1:2]`, k}
  - `o_sram_ren` = 1
  - The lane k byte returns the next cycle and is captured into `rdt[8k+:8]`. RWAIT captures lane 3.
  - `sel` is ignored for reads; all 4 bytes are read.
- **Address handling:** `adr` bits [1:0] and bits ≥ aw are ignored, so addresses wrap modulo memsize.
- **ACK:** `o_wb_dbg_ack` = 1 for exactly one cycle. `o_wb_dbg_rdt` holds its value until the next read captures.
- **Master rule:** the master deasserts `stb` on the edge where it samples ack. A `stb` still high in the cycle after ACK starts a new transaction.
- **Debug mode dropped mid-transaction:** the transaction completes and acks. The core regains the SRAM in the first IDLE cycle with `i_debug_mode` = 0.
- **Stray strobe:** `i_wb_dbg_stb` with `i_debug_mode` = 0 is ignored; no ack is ever given.
- **Reset (including mid-transaction):**
  - State → IDLE, lane counter 0, `o_wb_dbg_ack` 0, `o_wb_dbg_rdt` 0.
  - `o_sram_wen`/`o_sram_ren` are forced to 0 while `i_rst` is high.
  - The aborted transaction never acks.

## Timing
- Let N be the first cycle with `stb & i_debug_mode` high in IDLE.
- Lanes 0–3 occupy cycles N+1 to N+4.
- **Write:** ack is high in N+5.
- **Read:** ack is high in N+6, with `o_wb_dbg_rdt` valid in that same cycle.
- Back-to-back transactions are separated by at least one IDLE cycle.
- Core path: zero added latency (combinational mux).

## Configuration
- **`SUBSERVIENT_SRAM_ARB_DBG_READ_EN` defined:** debug reads behave as described above.
- **Macro undefined:**
  - A read request goes IDLE → ACK directly, with ack in N+1.
  - `o_wb_dbg_rdt` = 0 and `o_sram_ren` is never driven by debug.
  - The RWAIT state and `rdt` capture registers are not built.
  - Writes are unchanged.

## Structure
- Package `subservient_sram_arb_pkg`:
  - FSM state encoding (IDLE, LANE, RWAIT, ACK)
  - `LANES` = 4
  - `LANE_W` = 2
- Single module; no sub-module is needed (lane counter and mux are inline).

## Test plan
- **Write word:** `debug_mode`=1, write `adr`=0x10, `dat`=0xDEADBEEF, `sel`=0xF → SRAM byte writes at 0x10=EF, 0x11=BE, 0x12=AD, 0x13=DE in N+1..N+4; ack in N+5 only.
- **Partial write:** `sel`=0x5 to 0x20, `dat`=0x11223344 → `wen` only in lanes 0 and 2 (0x20=44, 0x22=22); ack in N+5.
- **Readback (macro on):** read 0x10 after the write above → `rdt`=0xDEADBEEF, ack in N+6. With the macro off: ack in N+1, `rdt`=0.
- **Arbitration:** core `wen` at 0x40 while `debug_mode`=1 → `o_sram_wen` stays 0 and `o_core_stall`=1. After `debug_mode`=0, the core write appears at the SRAM in the same cycle.
- **Reset mid-transaction:** `i_rst` asserted in lane 2 of a write → `wen` drops immediately, no ack. After release, a new write completes normally.
- **Stray strobe:** `stb` with `debug_mode`=0 → no ack for 20 cycles; core traffic is unaffected.

Source files
------------

// File: rtl/subservient_sram_arb_pkg.sv
// Shared constants and FSM state encoding for the subservient SRAM arbiter.
`default_nettype none

package subservient_sram_arb_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LANE  = 2'd1,
    ST_RWAIT = 2'd2,
    ST_ACK   = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/subservient_sram_arbiter.sv
// Shares the 8-bit SRAM port between the core byte path and the 32-bit Wishbone debug port.
// Define SUBSERVIENT_SRAM_ARB_DBG_READ_EN to build debug read support (RWAIT state, rdt capture).
`default_nettype none

module subservient_sram_arbiter
  import subservient_sram_arb_pkg::*;
#(
  parameter int memsize = 8192,
  parameter int aw      = $clog2(memsize)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_debug_mode,
  input  logic [aw-1:0] i_core_waddr,
  input  logic [7:0]    i_core_wdata,
  input  logic          i_core_wen,
  input  logic [aw-1:0] i_core_raddr,
  input  logic          i_core_ren,
  output logic [7:0]    o_core_rdata,
  output logic          o_core_stall,
  input  logic [31:0]   i_wb_dbg_adr,
  input  logic [31:0]   i_wb_dbg_dat,
  input  logic [3:0]    i_wb_dbg_sel,
  input  logic          i_wb_dbg_we,
  input  logic          i_wb_dbg_stb,
  output logic [31:0]   o_wb_dbg_rdt,
  output logic          o_wb_dbg_ack,
  output logic [aw-1:0] o_sram_waddr,
  output logic [7:0]    o_sram_wdata,
  output logic          o_sram_wen,
  output logic [aw-1:0] o_sram_raddr,
  output logic          o_sram_ren,
  input  logic [7:0]    i_sram_rdata
);

  arb_state_t        state;
  logic [LANE_W-1:0] lane;
  logic [aw-3:0]     adr_q;
  logic [31:0]       dat_q;
  logic [3:0]        sel_q;
  logic              we_q;
  logic              ack_q;
  logic              dbg_own;
  logic [aw-1:0]     lane_addr;
  logic              unused_adr_bits;

  // Word-select bits and bits above the SRAM size are deliberately dropped.
  assign unused_adr_bits = ^{i_wb_dbg_adr[31:aw], i_wb_dbg_adr[1:0]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      lane  <= '0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_debug_mode && i_wb_dbg_stb) begin
            adr_q <= i_wb_dbg_adr[aw-1:2];
            dat_q <= i_wb_dbg_dat;
            sel_q <= i_wb_dbg_sel;
            we_q  <= i_wb_dbg_we;
            lane  <= '0;
`ifdef SUBSERVIENT_SRAM_ARB_DBG_READ_EN
            state <= ST_LANE;
`else
            if (i_wb_dbg_we) begin
              state <= ST_LANE;
            end else begin
              state <= ST_ACK;
              ack_q <= 1'b1;
            end
`endif
          end
        end
        ST_LANE: begin
          lane <= lane + 1'b1;
          if (lane == LANE_W'(LANES - 1)) begin
`ifdef SUBSERVIENT_SRAM_ARB_DBG_READ_EN
            if (we_q) begin
              state <= ST_ACK;
              ack_q <= 1'b1;
            end else begin
              state <= ST_RWAIT;
            end
`else
            state <= ST_ACK;
            ack_q <= 1'b1;
`endif
          end
        end
        ST_RWAIT: begin
`ifdef SUBSERVIENT_SRAM_ARB_DBG_READ_EN
          state <= ST_ACK;
          ack_q <= 1'b1;
`else
          state <= ST_IDLE;
`endif
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SUBSERVIENT_SRAM_ARB_DBG_READ_EN
  logic [31:0] rdt_q;

  // Read data lags its lane by one cycle, so lane k's byte lands while lane k+1 issues.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdt_q <= '0;
    end else if (!we_q) begin
      if (state == ST_LANE) begin
        case (lane)
          2'd1:    rdt_q[7:0]   <= i_sram_rdata;
          2'd2:    rdt_q[15:8]  <= i_sram_rdata;
          2'd3:    rdt_q[23:16] <= i_sram_rdata;
          default: ;
        endcase
      end else if (state == ST_RWAIT) begin
        rdt_q[31:24] <= i_sram_rdata;
      end
    end
  end

  assign o_wb_dbg_rdt = rdt_q;
`else
  assign o_wb_dbg_rdt = '0;
`endif

  assign dbg_own      = (state != ST_IDLE) || i_debug_mode;
  assign lane_addr    = {adr_q, lane};
  assign o_wb_dbg_ack = ack_q;
  assign o_core_rdata = i_sram_rdata;
  assign o_core_stall = (i_core_wen || i_core_ren) && dbg_own;

  always_comb begin
    o_sram_waddr = i_core_waddr;
    o_sram_wdata = i_core_wdata;
    o_sram_wen   = i_core_wen && !dbg_own;
    o_sram_raddr = i_core_raddr;
    o_sram_ren   = i_core_ren && !dbg_own;
    if (dbg_own) begin
      o_sram_waddr = lane_addr;
      o_sram_wdata = dat_q[{lane, 3'b000} +: 8];
      o_sram_raddr = lane_addr;
      o_sram_wen   = 1'b0;
      o_sram_ren   = 1'b0;
      if (state == ST_LANE) begin
        o_sram_wen = we_q && sel_q[lane];
`ifdef SUBSERVIENT_SRAM_ARB_DBG_READ_EN
        o_sram_ren = !we_q;
`endif
      end
    end
    // Async reset clears state immediately, but the enables must also be held off.
    if (i_rst) begin
      o_sram_wen = 1'b0;
      o_sram_ren = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_subservient_sram_arbiter.sv
// Directed bench for subservient_sram_arbiter with a cycle-level transaction model.
`default_nettype none

module tb_subservient_sram_arbiter;

  localparam int MEMSIZE = 8192;
  localparam int AW      = 13;
`ifdef SUBSERVIENT_SRAM_ARB_DBG_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          debug_mode;
  logic [AW-1:0] core_waddr;
  logic [7:0]    core_wdata;
  logic          core_wen;
  logic [AW-1:0] core_raddr;
  logic          core_ren;
  logic [7:0]    core_rdata;
  logic          core_stall;
  logic [31:0]   wb_adr;
  logic [31:0]   wb_dat;
  logic [3:0]    wb_sel;
  logic          wb_we;
  logic          stb;
  logic [31:0]   wb_rdt;
  logic          wb_ack;
  logic [AW-1:0] sram_waddr;
  logic [7:0]    sram_wdata;
  logic          sram_wen;
  logic [AW-1:0] sram_raddr;
  logic          sram_ren;
  logic [7:0]    sram_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_cnt = 0;

  logic [7:0] mem [MEMSIZE];
  logic [7:0] model_mem [MEMSIZE];

  subservient_sram_arbiter #(.memsize(MEMSIZE)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_debug_mode (debug_mode),
    .i_core_waddr (core_waddr),
    .i_core_wdata (core_wdata),
    .i_core_wen   (core_wen),
    .i_core_raddr (core_raddr),
    .i_core_ren   (core_ren),
    .o_core_rdata (core_rdata),
    .o_core_stall (core_stall),
    .i_wb_dbg_adr (wb_adr),
    .i_wb_dbg_dat (wb_dat),
    .i_wb_dbg_sel (wb_sel),
    .i_wb_dbg_we  (wb_we),
    .i_wb_dbg_stb (stb),
    .o_wb_dbg_rdt (wb_rdt),
    .o_wb_dbg_ack (wb_ack),
    .o_sram_waddr (sram_waddr),
    .o_sram_wdata (sram_wdata),
    .o_sram_wen   (sram_wen),
    .o_sram_raddr (sram_raddr),
    .o_sram_ren   (sram_ren),
    .i_sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  // External SRAM: one-cycle read latency.
  initial begin : sram_env
    for (int i = 0; i < MEMSIZE; i++) begin
      mem[i] = 8'h00;
      model_mem[i] = 8'h00;
    end
    sram_rdata = 8'h00;
    forever begin
      @(posedge clk);
      if (sram_ren) sram_rdata <= mem[sram_raddr];
      if (sram_wen) mem[sram_waddr] = sram_wdata;
    end
  end

  // Model: a debug transaction started in cycle N owns cycles N+1..N+end;
  // lanes are N+1..N+4, ack at N+end.
  initial begin : compare
    int            cyc;
    int            n0;
    int            m_end;
    int            d;
    bit            act;
    bit            busy;
    bit            own;
    bit            is_lane;
    logic [31:0]   m_adr;
    logic [31:0]   m_dat;
    logic [3:0]    m_sel;
    logic          m_we;
    logic [31:0]   m_rdt;
    logic          e_wen;
    logic          e_ren;
    logic          e_ack;
    logic [AW-1:0] e_waddr;
    logic [AW-1:0] e_raddr;
    logic [AW-1:0] base;
    logic [7:0]    e_wdata;
    cyc = 0; n0 = 0; m_end = 0; act = 1'b0; m_rdt = '0;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        act   = 1'b0;
        m_rdt = '0;
      end else if (act && cyc > n0 + m_end) begin
        act = 1'b0;
      end
      d       = act ? cyc - n0 : 0;
      busy    = act && d >= 1;
      own     = busy || debug_mode;
      is_lane = busy && d <= 4 && (m_we || READ_EN);
      e_waddr = core_waddr;
      e_raddr = core_raddr;
      e_wdata = core_wdata;
      if (rst) begin
        e_wen = 1'b0;
        e_ren = 1'b0;
      end else if (is_lane) begin
        e_wen   = m_we && m_sel[d-1];
        e_ren   = !m_we;
        e_waddr = {m_adr[AW-1:2], 2'(d-1)};
        e_raddr = e_waddr;
        e_wdata = m_dat[8*(d-1) +: 8];
      end else begin
        e_wen = core_wen && !own;
        e_ren = core_ren && !own;
      end
      e_ack = busy && d == m_end;

      chk("sram_wen", sram_wen, e_wen);
      chk("sram_ren", sram_ren, e_ren);
      chk("dbg_ack", wb_ack, e_ack);
      chk("core_stall", core_stall, (core_wen || core_ren) && own);
      chk("core_rdata", core_rdata, sram_rdata);
      if (e_wen) begin
        chk("sram_waddr", sram_waddr, e_waddr);
        chk("sram_wdata", sram_wdata, e_wdata);
        model_mem[e_waddr] = e_wdata;
      end
      if (e_ren) chk("sram_raddr", sram_raddr, e_raddr);
      if (e_ack && !m_we) begin
        base  = {m_adr[AW-1:2], 2'b00};
        m_rdt = READ_EN ? {model_mem[base+3], model_mem[base+2], model_mem[base+1], model_mem[base]} : 32'h0;
      end
      if (!(busy && !m_we) || e_ack) chk("dbg_rdt", wb_rdt, m_rdt);
      if (wb_ack) ack_cnt++;

      if (!act && !rst && debug_mode && stb) begin
        act   = 1'b1;
        n0    = cyc;
        m_adr = wb_adr;
        m_dat = wb_dat;
        m_sel = wb_sel;
        m_we  = wb_we;
        m_end = wb_we ? 5 : (READ_EN ? 6 : 1);
      end
    end
  end

  task automatic dbg(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                     input logic we, input bit scramble, input bit drop_mode,
                     output int lat, output logic [31:0] rdt);
    debug_mode = 1'b1;
    wb_adr = adr; wb_dat = dat; wb_sel = sel; wb_we = we; stb = 1'b1;
    lat = -1;
    rdt = '0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (wb_ack) begin
        lat = j;
        rdt = wb_rdt;
        break;
      end
      @(posedge clk); #1;
      if (j == 0 && scramble) begin
        wb_dat = ~wb_dat;
        wb_sel = ~wb_sel;
        wb_adr = adr + 32'h100;
      end
      if (j == 1 && drop_mode) debug_mode = 1'b0;
    end
    if (lat < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL dbg_ack_timeout: got no ack, expected ack within 30 cycles");
    end
    @(posedge clk); #1;
    stb = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin : stim
    int          lat;
    logic [31:0] rdt;
    int          acks;
    rst = 1'b1; debug_mode = 1'b0; stb = 1'b0;
    core_waddr = '0; core_wdata = '0; core_wen = 1'b0; core_raddr = '0; core_ren = 1'b0;
    wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ack", wb_ack, 1'b0);
    chk("reset_rdt", wb_rdt, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Full word write
    dbg(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b0, lat, rdt);
    chk("wr_latency", lat, 5);
    @(negedge clk);
    chk("wr_mem_10", mem_word(13'h10), 32'hDEADBEEF);
    chk("model_mem_10", {model_mem[13'h13], model_mem[13'h12], model_mem[13'h11], model_mem[13'h10]}, 32'hDEADBEEF);

    // Partial write, bus scrambled and debug_mode dropped mid-transaction
    @(posedge clk); #1;
    dbg(32'h20, 32'h11223344, 4'h5, 1'b1, 1'b1, 1'b1, lat, rdt);
    chk("pwr_latency", lat, 5);
    @(negedge clk);
    chk("pwr_mem_20", mem_word(13'h20), 32'h00220044);
    chk("pwr_mem_120", mem_word(13'h120), 32'h0);

    // Readback through a wrapped, unaligned address
    @(posedge clk); #1;
    dbg(32'hFFFF_E013, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, lat, rdt);
    chk("rd_latency", lat, READ_EN ? 6 : 1);
    chk("rd_data", rdt, READ_EN ? 32'hDEADBEEF : 32'h0);
    @(posedge clk); #1;
    dbg(32'h20, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, lat, rdt);
    chk("rd2_data", rdt, READ_EN ? 32'h00220044 : 32'h0);

    // Arbitration: core write held off while debug owns
    @(posedge clk); #1;
    debug_mode = 1'b1;
    core_wen = 1'b1; core_waddr = 13'h40; core_wdata = 8'h5A;
    @(negedge clk);
    chk("arb_stall", core_stall, 1'b1);
    chk("arb_wen_blocked", sram_wen, 1'b0);
    repeat (2) @(posedge clk); #1;
    debug_mode = 1'b0;
    @(negedge clk);
    chk("arb_wen_pass", sram_wen, 1'b1);
    chk("arb_stall_clear", core_stall, 1'b0);
    @(posedge clk); #1;
    core_wen = 1'b0;
    @(negedge clk);
    chk("arb_mem_40", mem[13'h40], 8'h5A);

    // Reset asserted in lane 2 of a write
    @(posedge clk); #1;
    acks = ack_cnt;
    debug_mode = 1'b1;
    wb_adr = 32'h50; wb_dat = 32'hA1B2C3D4; wb_sel = 4'hF; wb_we = 1'b1; stb = 1'b1;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wen_drop", sram_wen, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; stb = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_mem_50", mem_word(13'h50), 32'h0000C3D4);
    chk("rst_no_ack", ack_cnt, acks);
    @(posedge clk); #1;
    dbg(32'h50, 32'h01020304, 4'hF, 1'b1, 1'b0, 1'b0, lat, rdt);
    chk("post_rst_latency", lat, 5);
    @(negedge clk);
    chk("post_rst_mem_50", mem_word(13'h50), 32'h01020304);

    // Stray strobe without debug_mode, core traffic running
    @(posedge clk); #1;
    debug_mode = 1'b0;
    acks = ack_cnt;
    wb_we = 1'b1; stb = 1'b1;
    for (int i = 0; i < 20; i++) begin
      core_wen = (i % 2) == 0;
      core_waddr = 13'h60 + 13'(i);
      core_wdata = 8'(i);
      core_ren = 1'b1;
      core_raddr = 13'h12;
      @(posedge clk); #1;
    end
    stb = 1'b0; core_wen = 1'b0; core_ren = 1'b0;
    @(negedge clk);
    chk("stray_no_ack", ack_cnt, acks);
    chk("stray_core_rdata", core_rdata, 8'hAD);
    chk("stray_mem_6a", mem[13'h6A], 8'h0A);
    chk("stray_mem_6b", mem[13'h6B], 8'h00);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
